// File: rtl/stim_switch_sequencer.sv
// Electrode switch / current DAC sequencer with break-before-make dead time, DAC settle
// and post-pair discharge. Define STIM_SOFT_RAMP_EN to ramp dac_code up by 1 per cycle.
module stim_switch_sequencer #(
    parameter int unsigned DEADTIME  = 4,
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned DISCHARGE = 16,
    parameter int unsigned CW        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_st,
    input  logic [4:0] mag_st,
    input  logic [2:0] chsel_hs,
    input  logic [2:0] chsel_ls,
    output logic [7:0] sw_hs,
    output logic [7:0] sw_ls,
    output logic [7:0] sw_short,
    output logic       dac_en,
    output logic [4:0] dac_code,
    output logic       busy,
    output logic       conflict_err
);

    typedef enum logic [2:0] {
        StIdle,
        StBlock,
        StDtOn,
        StDrive,
        StDtOff,
        StShort
    } state_e;

    localparam logic [CW-1:0] DtLoad  = CW'(DEADTIME - 1);
    localparam logic [CW-1:0] StLoad  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DisLoad = CW'(DISCHARGE - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          pend_q, pend_d;
    logic          en_d;
    logic [2:0]    hs_q, hs_d, ls_q, ls_d;
    logic [4:0]    mag_q, mag_d;
    logic [2:0]    p_hs_q, p_hs_d, p_ls_q, p_ls_d;
    logic [4:0]    p_mag_q, p_mag_d;
    logic          closed_q, closed_d;
    logic          dac_on_q, dac_on_d;
    logic          err_q, err_d;
`ifdef STIM_SOFT_RAMP_EN
    logic [4:0]    code_q, code_d;
`endif

    logic rise, fall, conflict;
    assign rise     = en_st & ~en_d;
    assign fall     = ~en_st & en_d;
    assign conflict = (chsel_hs == chsel_ls);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        pend_d   = pend_q;
        hs_d     = hs_q;
        ls_d     = ls_q;
        mag_d    = mag_q;
        p_hs_d   = p_hs_q;
        p_ls_d   = p_ls_q;
        p_mag_d  = p_mag_q;
        closed_d = closed_q;
        dac_on_d = dac_on_q;
        err_d    = err_q;
`ifdef STIM_SOFT_RAMP_EN
        code_d   = code_q;
`endif

        // Requests arriving while the previous pair winds down are queued, not dropped.
        if (state_q == StDtOff || state_q == StShort) begin
            if (rise) begin
                if (conflict) begin
                    err_d = 1'b1;
                end else begin
                    pend_d  = 1'b1;
                    p_hs_d  = chsel_hs;
                    p_ls_d  = chsel_ls;
                    p_mag_d = mag_st;
                end
            end else if (fall) begin
                pend_d = 1'b0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (en_st) begin
                        hs_d    = p_hs_q;
                        ls_d    = p_ls_q;
                        mag_d   = p_mag_q;
                        cnt_d   = DtLoad;
                        state_d = StDtOn;
                    end
                end else if (rise) begin
                    if (conflict) begin
                        err_d   = 1'b1;
                        state_d = StBlock;
                    end else begin
                        hs_d    = chsel_hs;
                        ls_d    = chsel_ls;
                        mag_d   = mag_st;
                        cnt_d   = DtLoad;
                        state_d = StDtOn;
                    end
                end
            end
            StBlock: begin
                if (fall) state_d = StIdle;
            end
            StDtOn: begin
                if (fall) begin
                    cnt_d   = DtLoad;
                    state_d = StDtOff;
                end else if (cnt_q == '0) begin
                    cnt_d    = StLoad;
                    closed_d = 1'b1;
                    state_d  = StDrive;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDrive: begin
                if (fall) begin
                    dac_on_d = 1'b0;
                    cnt_d    = DtLoad;
                    state_d  = StDtOff;
`ifdef STIM_SOFT_RAMP_EN
                    code_d   = '0;
`endif
                end else if (cnt_q == '0) begin
                    dac_on_d = 1'b1;
`ifdef STIM_SOFT_RAMP_EN
                    if (!dac_on_q) begin
                        code_d = (mag_q == '0) ? 5'd0 : 5'd1;
                    end else if (code_q < mag_q) begin
                        code_d = code_q + 5'd1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDtOff: begin
                if (cnt_q == '0) begin
                    closed_d = 1'b0;
                    phase_d  = ~phase_q;
                    if (phase_q) begin
                        cnt_d   = DisLoad;
                        state_d = StShort;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShort: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            pend_q   <= 1'b0;
            en_d     <= 1'b0;
            hs_q     <= '0;
            ls_q     <= '0;
            mag_q    <= '0;
            p_hs_q   <= '0;
            p_ls_q   <= '0;
            p_mag_q  <= '0;
            closed_q <= 1'b0;
            dac_on_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef STIM_SOFT_RAMP_EN
            code_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            en_d     <= en_st;
            hs_q     <= hs_d;
            ls_q     <= ls_d;
            mag_q    <= mag_d;
            p_hs_q   <= p_hs_d;
            p_ls_q   <= p_ls_d;
            p_mag_q  <= p_mag_d;
            closed_q <= closed_d;
            dac_on_q <= dac_on_d;
            err_q    <= err_d;
`ifdef STIM_SOFT_RAMP_EN
            code_q   <= code_d;
`endif
        end
    end

    // Cathodic phase (phase_q=1) reverses current direction by swapping source and sink.
    logic [2:0] src, snk;
    logic       drive_sw;
    always_comb begin
        src      = phase_q ? ls_q : hs_q;
        snk      = phase_q ? hs_q : ls_q;
        drive_sw = (state_q == StDrive) || (state_q == StDtOff && closed_q);
        sw_hs    = drive_sw ? (8'd1 << src) : 8'd0;
        sw_ls    = drive_sw ? (8'd1 << snk) : 8'd0;
        sw_short = (state_q == StShort) ? ((8'd1 << hs_q) | (8'd1 << ls_q)) : 8'd0;
        dac_en   = dac_on_q;
`ifdef STIM_SOFT_RAMP_EN
        dac_code = dac_on_q ? code_q : 5'd0;
`else
        dac_code = dac_on_q ? mag_q : 5'd0;
`endif
        busy         = (state_q != StIdle);
        conflict_err = err_q;
    end

endmodule
